unidade_busca: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the word address into memory, and registers the returned 32-bit instruction, with its PC, into a fetch/decode pipeline register. It handles stall/backpressure from decode via a valid/ready handshake and redirects from the branch/jump logic. On a redirect it flushes the wrong-path entry, and it halts cleanly when the PC leaves the memory range.

---
 rtl/unidade_busca_pkg.sv | 22 ++
 rtl/unidade_busca.sv | 119 +++++++++++
 tb/tb_unidade_busca.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/unidade_busca_pkg.sv
// ============================================================================
// unidade_busca_pkg
// Shared defaults, widths and FSM state encoding for the fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package unidade_busca_pkg;

    localparam int unsigned     PC_W_PADRAO      = 64;
    localparam int unsigned     MEM_WORDS_PADRAO = 64;
    localparam longint unsigned RESET_PC_PADRAO  = 64'd0;
    localparam int unsigned     INSTR_W          = 32;

    typedef enum logic [0:0] {
        BUSCA  = 1'b0,
        PARADO = 1'b1
    } estado_e;

endpackage

`default_nettype wire

// File: rtl/unidade_busca.sv
// ============================================================================
// unidade_busca
// Instruction fetch: PC, fetch/decode register with valid/ready, redirect and
// out-of-range halt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int unsigned       PC_W      = PC_W_PADRAO,
    parameter int unsigned       MEM_WORDS = MEM_WORDS_PADRAO,
    parameter logic [PC_W-1:0]   RESET_PC  = PC_W'(RESET_PC_PADRAO)
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [PC_W-1:0]      pc_mem,
    input  logic [INSTR_W-1:0]   instrucao,
    input  logic                 desvio,
    input  logic [PC_W-1:0]      desvio_pc,
    input  logic                 pronto,
    output logic                 if_valido,
    output logic [INSTR_W-1:0]   if_instrucao,
    output logic [PC_W-1:0]      if_pc,
    output logic [PC_W-1:0]      if_pc_mais1,
    output logic                 fora_faixa,
    output logic [31:0]          n_entregues
);

    localparam logic [PC_W-1:0] MEM_LIMITE = PC_W'(MEM_WORDS);

    estado_e              estado_q, estado_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 valido_q, valido_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      ifpc_q, ifpc_d;
    logic [PC_W-1:0]      ifpc1_q, ifpc1_d;
    logic [31:0]          cont_q, cont_d;

    logic                 w_transfer;
    logic                 w_livre;
    logic                 w_em_faixa;

    assign w_transfer = valido_q & pronto & ~desvio;
    assign w_livre    = ~valido_q | pronto;
    assign w_em_faixa = (pc_q < MEM_LIMITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= BUSCA;
            pc_q     <= RESET_PC;
            valido_q <= 1'b0;
            instr_q  <= '0;
            ifpc_q   <= '0;
            ifpc1_q  <= '0;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            valido_q <= valido_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            ifpc1_q  <= ifpc1_d;
            cont_q   <= cont_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        valido_d = valido_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        ifpc1_d  = ifpc1_q;
        cont_d   = cont_q + {31'd0, w_transfer};

        // Redirect squashes the wrong-path entry regardless of state or stall.
        if (desvio) begin
            pc_d     = desvio_pc;
            valido_d = 1'b0;
            estado_d = BUSCA;
        end else begin
            case (estado_q)
                BUSCA: begin
                    if (w_livre) begin
                        if (w_em_faixa) begin
                            instr_d  = instrucao;
                            ifpc_d   = pc_q;
                            ifpc1_d  = pc_q + 1'b1;
                            valido_d = 1'b1;
                            pc_d     = pc_q + 1'b1;
                        end else begin
                            valido_d = 1'b0;
                            estado_d = PARADO;
                        end
                    end
                end
                PARADO: begin
                    if (pronto) begin
                        valido_d = 1'b0;
                    end
                end
                default: estado_d = BUSCA;
            endcase
        end
    end

    assign pc_mem       = pc_q;
    assign if_valido    = valido_q;
    assign if_instrucao = instr_q;
    assign if_pc        = ifpc_q;
    assign if_pc_mais1  = ifpc1_q;
    assign fora_faixa   = (estado_q == PARADO);
    assign n_entregues  = cont_q;

endmodule

`default_nettype wire

// File: tb/tb_unidade_busca.sv
// ============================================================================
// tb_unidade_busca
// Randomized self-checking bench for unidade_busca against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unidade_busca;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  pc_mem;
    logic [31:0]  instrucao;
    logic         desvio = 1'b0;
    logic [63:0]  desvio_pc = '0;
    logic         pronto = 1'b0;
    logic         if_valido;
    logic [31:0]  if_instrucao;
    logic [63:0]  if_pc;
    logic [63:0]  if_pc_mais1;
    logic         fora_faixa;
    logic [31:0]  n_entregues;

    logic [31:0]  mem [64];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    longint unsigned m_pc;
    bit              m_val;
    bit              m_par;
    logic [31:0]     m_ins;
    longint unsigned m_ipc;
    longint unsigned m_ipc1;
    int unsigned     m_cnt;

    unidade_busca dut (
        .clock        (clock),
        .reset        (reset),
        .pc_mem       (pc_mem),
        .instrucao    (instrucao),
        .desvio       (desvio),
        .desvio_pc    (desvio_pc),
        .pronto       (pronto),
        .if_valido    (if_valido),
        .if_instrucao (if_instrucao),
        .if_pc        (if_pc),
        .if_pc_mais1  (if_pc_mais1),
        .fora_faixa   (fora_faixa),
        .n_entregues  (n_entregues)
    );

    always #5 clock = ~clock;

    assign instrucao = (pc_mem < 64'd64) ? mem[pc_mem[5:0]] : 32'hDEAD_BEEF;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic modelo_reset();
        m_pc = 0; m_val = 0; m_par = 0; m_ins = '0;
        m_ipc = 0; m_ipc1 = 0; m_cnt = 0;
    endtask

    task automatic confere_tudo(input string tag);
        verifica({tag, ".pc_mem"},  pc_mem,              m_pc);
        verifica({tag, ".valido"},  {63'd0, if_valido},  {63'd0, m_val});
        verifica({tag, ".instr"},   {32'd0, if_instrucao}, {32'd0, m_ins});
        verifica({tag, ".if_pc"},   if_pc,               m_ipc);
        verifica({tag, ".pc1"},     if_pc_mais1,         m_ipc1);
        verifica({tag, ".fora"},    {63'd0, fora_faixa}, {63'd0, m_par});
        verifica({tag, ".cont"},    {32'd0, n_entregues}, {32'd0, m_cnt});
    endtask

    // Called at a falling edge: apply inputs, advance one rising edge, update
    // the model from the rules, then compare at the next falling edge.
    task automatic passo(input bit dv, input logic [63:0] dpc, input bit pr, input string tag);
        desvio    = dv;
        desvio_pc = dpc;
        pronto    = pr;
        @(posedge clock);
        if (m_val && pr && !dv) m_cnt++;
        if (dv) begin
            m_pc  = dpc;
            m_val = 0;
            m_par = 0;
        end else if (!m_par) begin
            if (!m_val || pr) begin
                if (m_pc < 64) begin
                    m_ins  = mem[m_pc[5:0]];
                    m_ipc  = m_pc;
                    m_ipc1 = m_pc + 1;
                    m_val  = 1;
                    m_pc   = m_pc + 1;
                end else begin
                    m_val = 0;
                    m_par = 1;
                end
            end
        end else if (pr) begin
            m_val = 0;
        end
        @(negedge clock);
        confere_tudo(tag);
    endtask

    initial begin
        logic [63:0] alvo;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h0070_2083;
        modelo_reset();

        #12;
        confere_tudo("reset");
        @(negedge clock);
        reset = 1'b1;

        passo(0, '0, 1, "c1");
        verifica("tp_c1_pc", if_pc, 64'd0);
        passo(0, '0, 1, "c2");
        verifica("tp_c2_pc", if_pc, 64'd1);
        verifica("tp_c2_instr", {32'd0, if_instrucao}, 64'h0070_2083);
        verifica("tp_c2_pc1", if_pc_mais1, 64'd2);
        passo(0, '0, 1, "c3");
        for (int i = 0; i < 3; i++) passo(0, '0, 0, "stall");
        verifica("tp_stall_pc", if_pc, 64'd2);
        passo(0, '0, 1, "rel1");
        verifica("tp_rel_pc", if_pc, 64'd3);
        for (int i = 0; i < 4; i++) passo(0, '0, 1, "run");
        verifica("tp_held7", if_pc, 64'd7);

        // Redirect together with ~pronto: redirect wins, entry squashed.
        passo(1, 64'd10, 0, "desv10");
        verifica("tp_desv_val", {63'd0, if_valido}, 64'd0);
        verifica("tp_desv_pcmem", pc_mem, 64'd10);
        passo(0, '0, 1, "pos10");
        verifica("tp_pos10", if_pc, 64'd10);

        passo(1, 64'd62, 1, "desv62");
        passo(0, '0, 1, "f62");
        verifica("tp_f62", if_pc, 64'd62);
        passo(0, '0, 1, "f63");
        verifica("tp_f63", if_pc, 64'd63);
        passo(0, '0, 1, "f64");
        verifica("tp_fora", {63'd0, fora_faixa}, 64'd1);
        verifica("tp_fora_val", {63'd0, if_valido}, 64'd0);
        passo(0, '0, 1, "parado");
        passo(1, 64'd5, 1, "desv5");
        passo(0, '0, 1, "f5");
        verifica("tp_f5", if_pc, 64'd5);
        verifica("tp_f5_fora", {63'd0, fora_faixa}, 64'd0);

        // Out-of-range redirect target, including one that wraps on +1.
        passo(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "desv_max");
        passo(0, '0, 0, "max_parar");
        verifica("tp_max_fora", {63'd0, fora_faixa}, 64'd1);

        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                0: alvo = 64'($urandom_range(0, 70));
                1: alvo = 64'($urandom_range(58, 66));
                2: alvo = {32'hFFFF_FFFF, $urandom};
                default: alvo = 64'($urandom_range(0, 63));
            endcase
            passo(($urandom_range(0, 9) == 0), alvo, ($urandom_range(0, 9) < 7), "rand");

            if (i == 1000) begin
                @(posedge clock);
                #2;
                reset = 1'b0;
                #1;
                verifica("arst_valido", {63'd0, if_valido}, 64'd0);
                verifica("arst_cont", {32'd0, n_entregues}, 64'd0);
                verifica("arst_pcmem", pc_mem, 64'd0);
                verifica("arst_fora", {63'd0, fora_faixa}, 64'd0);
                modelo_reset();
                @(negedge clock);
                reset = 1'b1;
                passo(0, '0, 1, "pos_rst");
                verifica("tp_pos_rst_pc", if_pc, 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
